// File: rtl/spi_xfer_ctrl.sv
// SPI master character sequencer: frames cs_n, runs spi_clk_gen via go/last_clk,
// shifts MOSI and samples MISO on the clk_gen edge strobes.
module spi_xfer_ctrl #(
  parameter int CHAR_NBITS = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CNT_W-1:0]      char_len,
  input  logic                  lsb_first,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [CHAR_NBITS-1:0] tx_data,
  output logic                  rx_valid,
  output logic [CHAR_NBITS-1:0] rx_data,
  output logic                  go,
  output logic                  last_clk,
  input  logic                  pos_edge,
  input  logic                  neg_edge,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy
);
  localparam int IDX_W = (CHAR_NBITS > 1) ? $clog2(CHAR_NBITS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, LAST, DONE} state_e;
  state_e state_q, state_d;

  logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, first_q, first_d;
  logic                  go_q, go_d, last_q, last_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  idx_t                  len_q, len_d, rx_idx_q, rx_idx_d, len_c;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CHAR_NBITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_nx;
  logic                  pe, ne, lead, trail, do_sample, do_shift, load, fin;

  // Coincident strobes are treated as a glitch and dropped.
  assign pe    = pos_edge & ~neg_edge;
  assign ne    = neg_edge & ~pos_edge;
  assign lead  = cpol_q ? ne : pe;
  assign trail = cpol_q ? pe : ne;
  assign len_c = (char_len > CNT_W'(CHAR_NBITS-1)) ? idx_t'(CHAR_NBITS-1) : idx_t'(char_len);
  assign tx_nx = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    first_d   = first_q;
    go_d      = go_q;
    last_d    = last_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    len_d     = len_q;
    rx_idx_d  = rx_idx_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    load      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    fin       = 1'b0;

    case (state_q)
      IDLE: begin
        // Held off while in reset so the handshake cannot fire on release.
        tx_ready = enable & rst_n;
        load     = tx_valid & enable;
      end
      SETUP: begin
        go_d    = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        do_sample = cpha_q ? trail : lead;
        do_shift  = cpha_q ? (lead & ~first_q) : trail;
        if (lead) begin
          first_d = 1'b0;
          if (bit_cnt_q == '0) begin
            last_d  = 1'b1;
            state_d = LAST;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      LAST: begin
        do_sample = cpha_q & trail;
        if (trail) begin
          go_d    = 1'b0;
          last_d  = 1'b0;
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rx_valid = 1'b1;
        tx_ready = enable;
        load     = tx_valid & enable;
        if (!load) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_sample) begin
      rx_idx_d = rx_idx_q + 1'b1;
      if (lsb_q) rx_sh_d[rx_idx_q] = miso;
      else       rx_sh_d = {rx_sh_q[CHAR_NBITS-2:0], miso};
    end
    if (do_shift) begin
      tx_sh_d = tx_nx;
      mosi_d  = lsb_q ? tx_nx[0] : tx_nx[len_q];
    end
    if (fin) rx_data_d = rx_sh_d;

    if (load) begin
      state_d   = SETUP;
      cs_n_d    = 1'b0;
      cpol_d    = cpol;
      cpha_d    = cpha;
      lsb_d     = lsb_first;
      len_d     = len_c;
      bit_cnt_d = CNT_W'(len_c);
      tx_sh_d   = tx_data;
      rx_sh_d   = '0;
      rx_idx_d  = '0;
      first_d   = 1'b1;
      mosi_d    = lsb_first ? tx_data[0] : tx_data[len_c];
    end

    if (!enable) begin
      state_d   = IDLE;
      go_d      = 1'b0;
      last_d    = 1'b0;
      cs_n_d    = 1'b1;
      rx_data_d = rx_data_q;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      first_q   <= 1'b0;
      go_q      <= 1'b0;
      last_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      len_q     <= '0;
      rx_idx_q  <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      first_q   <= first_d;
      go_q      <= go_d;
      last_q    <= last_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      len_q     <= len_d;
      rx_idx_q  <= rx_idx_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign go       = go_q;
  assign last_clk = last_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: a small clk_gen stand-in produces the
// edge strobes and MISO is looped back from MOSI.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;
  localparam int CHAR_NBITS = 16;
  localparam int CNT_W      = 5;

  logic sysclk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, tx_valid = 1'b0;
  logic [CNT_W-1:0]      char_len = '0;
  logic [CHAR_NBITS-1:0] tx_data = '0;
  logic [CHAR_NBITS-1:0] rx_data;
  logic tx_ready, rx_valid, go, last_clk, mosi, cs_n, busy, miso;
  logic pos_edge = 1'b0, neg_edge = 1'b0, sclk = 1'b0;
  int   cdiv = 0;
  int   vec = 0, miss = 0;
  int   lead_total = 0;

  always #5 sysclk = ~sysclk;
  assign miso = mosi;

  spi_xfer_ctrl #(.CHAR_NBITS(CHAR_NBITS), .CNT_W(CNT_W)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .cpol(cpol), .cpha(cpha),
    .char_len(char_len), .lsb_first(lsb_first), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data), .go(go), .last_clk(last_clk),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .miso(miso), .mosi(mosi), .cs_n(cs_n), .busy(busy)
  );

  // clk_gen stand-in: SCLK toggles every 2 sysclk while go is high
  always @(posedge sysclk) begin
    if (!go) begin
      sclk <= cpol; cdiv <= 0; pos_edge <= 1'b0; neg_edge <= 1'b0;
    end else if (cdiv == 1) begin
      cdiv <= 0; sclk <= ~sclk; pos_edge <= ~sclk; neg_edge <= sclk;
    end else begin
      cdiv <= cdiv + 1; pos_edge <= 1'b0; neg_edge <= 1'b0;
    end
  end

  always @(negedge sysclk)
    if (go && (cpol ? neg_edge : pos_edge)) lead_total <= lead_total + 1;

  task automatic start_char(input logic p, input logic h, input logic [CNT_W-1:0] len,
                            input logic lsb, input logic [CHAR_NBITS-1:0] d);
    cpol = p; cpha = h; char_len = len; lsb_first = lsb; tx_data = d; tx_valid = 1'b1;
    @(negedge sysclk);
    tx_valid = 1'b0;
  endtask

  // Returns at the negedge where rx_valid is seen, plus go/pos_edge of the cycle before.
  task automatic wait_done(output bit seen, output logic pgo, output logic ppos);
    seen = 1'b0; pgo = 1'b0; ppos = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      pgo = go; ppos = pos_edge;
      @(negedge sysclk);
      seen = rx_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; tx_valid = 1'b1; tx_data = 16'hFFFF;
    #13;
    vec++; if (cs_n !== 1'b1)     begin miss++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    vec++; if (go !== 1'b0)       begin miss++; $display("FAIL rst_go: got %b want 0", go); end
    vec++; if (last_clk !== 1'b0) begin miss++; $display("FAIL rst_last_clk: got %b want 0", last_clk); end
    vec++; if (tx_ready !== 1'b0) begin miss++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
    vec++; if (rx_valid !== 1'b0) begin miss++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    vec++; if (rx_data !== 16'h0) begin miss++; $display("FAIL rst_rx_data: got %h want 0000", rx_data); end
    vec++; if (mosi !== 1'b0)     begin miss++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    vec++; if (busy !== 1'b0)     begin miss++; $display("FAIL rst_busy: got %b want 0", busy); end
    tx_valid = 1'b0;
    @(negedge sysclk); rst_n = 1'b1;
    @(negedge sysclk);
    vec++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miss++; $display("FAIL rst_release: got ready=%b busy=%b want 1 0", tx_ready, busy); end
  endtask

  task automatic test_mode0();
    int l0; bit seen; logic pgo, ppos;
    l0 = lead_total;
    start_char(1'b0, 1'b0, 5'd7, 1'b0, 16'h00A5);
    vec++; if (cs_n !== 1'b0 || busy !== 1'b1 || go !== 1'b0 || mosi !== 1'b1)
      begin miss++; $display("FAIL m0_setup: got cs_n=%b busy=%b go=%b mosi=%b want 0 1 0 1", cs_n, busy, go, mosi); end
    @(negedge sysclk);
    vec++; if (go !== 1'b1) begin miss++; $display("FAIL m0_go_rise: got %b want 1", go); end
    wait_done(seen, pgo, ppos);
    vec++; if (!seen) begin miss++; $display("FAIL m0_timeout: got no rx_valid want rx_valid"); end
    vec++; if (rx_data !== 16'h00A5) begin miss++; $display("FAIL m0_rx_data: got %h want 00a5", rx_data); end
    vec++; if (lead_total - l0 != 8) begin miss++; $display("FAIL m0_leads: got %0d want 8", lead_total - l0); end
    @(negedge sysclk);
    vec++; if (rx_valid !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0)
      begin miss++; $display("FAIL m0_after_done: got rx_valid=%b cs_n=%b busy=%b want 0 1 0", rx_valid, cs_n, busy); end
  endtask

  task automatic test_mode3();
    int l0; bit seen; logic pgo, ppos;
    l0 = lead_total;
    start_char(1'b1, 1'b1, 5'd15, 1'b1, 16'h1234);
    vec++; if (mosi !== 1'b0 || cs_n !== 1'b0) begin miss++; $display("FAIL m3_first_bit: got mosi=%b cs_n=%b want 0 0", mosi, cs_n); end
    wait_done(seen, pgo, ppos);
    vec++; if (!seen) begin miss++; $display("FAIL m3_timeout: got no rx_valid want rx_valid"); end
    vec++; if (rx_data !== 16'h1234) begin miss++; $display("FAIL m3_rx_data: got %h want 1234", rx_data); end
    vec++; if (lead_total - l0 != 16) begin miss++; $display("FAIL m3_leads: got %0d want 16", lead_total - l0); end
    vec++; if (pgo !== 1'b1 || ppos !== 1'b1 || go !== 1'b0)
      begin miss++; $display("FAIL m3_go_fall: got prev_go=%b prev_pos=%b go=%b want 1 1 0", pgo, ppos, go); end
    @(negedge sysclk);
  endtask

  task automatic test_back_to_back();
    int cs_hi, pulses; logic [15:0] d1, d2; bit seen;
    cs_hi = 0; pulses = 0; d1 = '0; d2 = '0;
    cpol = 1'b0; cpha = 1'b1; char_len = 5'd7; lsb_first = 1'b0; tx_data = 16'h003C; tx_valid = 1'b1;
    @(negedge sysclk);
    tx_data = 16'h00C3;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sysclk);
      if (cs_n !== 1'b0) cs_hi++;
      seen = rx_valid;
    end
    if (seen) begin pulses++; d1 = rx_data; end
    @(negedge sysclk);
    tx_valid = 1'b0;
    vec++; if (go !== 1'b0 || busy !== 1'b1 || cs_n !== 1'b0)
      begin miss++; $display("FAIL burst_setup: got go=%b busy=%b cs_n=%b want 0 1 0", go, busy, cs_n); end
    @(negedge sysclk);
    vec++; if (go !== 1'b1) begin miss++; $display("FAIL burst_go_rise: got %b want 1", go); end
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sysclk);
      if (cs_n !== 1'b0) cs_hi++;
      seen = rx_valid;
    end
    if (seen) begin pulses++; d2 = rx_data; end
    vec++; if (pulses != 2) begin miss++; $display("FAIL burst_pulses: got %0d want 2", pulses); end
    vec++; if (d1 !== 16'h003C || d2 !== 16'h00C3) begin miss++; $display("FAIL burst_rx_data: got %h %h want 003c 00c3", d1, d2); end
    vec++; if (cs_hi != 0) begin miss++; $display("FAIL burst_cs_n: got %0d high cycles want 0", cs_hi); end
    @(negedge sysclk);
    vec++; if (cs_n !== 1'b1 || rx_valid !== 1'b0) begin miss++; $display("FAIL burst_end: got cs_n=%b rx_valid=%b want 1 0", cs_n, rx_valid); end
  endtask

  task automatic test_clamp();
    int l0; bit seen; logic pgo, ppos;
    l0 = lead_total;
    start_char(1'b0, 1'b0, 5'd20, 1'b0, 16'hBEEF);
    vec++; if (mosi !== 1'b1) begin miss++; $display("FAIL clamp_first_bit: got %b want 1", mosi); end
    wait_done(seen, pgo, ppos);
    vec++; if (!seen || rx_data !== 16'hBEEF) begin miss++; $display("FAIL clamp_rx_data: got %h want beef", rx_data); end
    vec++; if (lead_total - l0 != 16) begin miss++; $display("FAIL clamp_leads: got %0d want 16", lead_total - l0); end
    @(negedge sysclk);
  endtask

  task automatic test_abort();
    int l0, bad;
    l0 = lead_total; bad = 0;
    start_char(1'b0, 1'b0, 5'd7, 1'b0, 16'h0096);
    for (int i = 0; i < 100 && (lead_total - l0) < 3; i++) @(negedge sysclk);
    vec++; if (lead_total - l0 != 3) begin miss++; $display("FAIL abort_reach: got %0d leads want 3", lead_total - l0); end
    enable = 1'b0;
    @(negedge sysclk);
    vec++; if (go !== 1'b0 || cs_n !== 1'b1 || last_clk !== 1'b0 || busy !== 1'b0)
      begin miss++; $display("FAIL abort_stop: got go=%b cs_n=%b last=%b busy=%b want 0 1 0 0", go, cs_n, last_clk, busy); end
    vec++; if (rx_data !== 16'hBEEF) begin miss++; $display("FAIL abort_rx_hold: got %h want beef", rx_data); end
    for (int i = 0; i < 20; i++) begin
      if (rx_valid !== 1'b0 || tx_ready !== 1'b0 || go !== 1'b0) bad++;
      @(negedge sysclk);
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    vec++; if (lead_total - l0 != 3) begin miss++; $display("FAIL abort_leads: got %0d want 3", lead_total - l0); end
    enable = 1'b1;
    @(negedge sysclk);
    vec++; if (tx_ready !== 1'b1) begin miss++; $display("FAIL abort_ready_back: got %b want 1", tx_ready); end
  endtask

  task automatic test_reset_mid();
    int l0; bit seen; logic pgo, ppos;
    l0 = lead_total;
    start_char(1'b0, 1'b0, 5'd7, 1'b0, 16'h0077);
    for (int i = 0; i < 100 && (lead_total - l0) < 2; i++) @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    vec++; if (cs_n !== 1'b1 || go !== 1'b0 || busy !== 1'b0)
      begin miss++; $display("FAIL rstmid_async: got cs_n=%b go=%b busy=%b want 1 0 0", cs_n, go, busy); end
    @(negedge sysclk); rst_n = 1'b1;
    @(negedge sysclk);
    l0 = lead_total;
    start_char(1'b0, 1'b0, 5'd7, 1'b0, 16'h005A);
    wait_done(seen, pgo, ppos);
    vec++; if (!seen || rx_data !== 16'h005A) begin miss++; $display("FAIL rstmid_rx_data: got %h want 005a", rx_data); end
    vec++; if (lead_total - l0 != 8) begin miss++; $display("FAIL rstmid_leads: got %0d want 8", lead_total - l0); end
    @(negedge sysclk);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_clamp();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name:
spi_xfer_ctrl

Overview:
- Character-level SPI master sequencer that drives the `spi_clk_gen` divider through its `go`/`last_clk` controls.
- Consumes the `pos_edge`/`neg_edge` strobes to count bits, shift MOSI, sample MISO and frame `cs_n`.
- Provides a valid/ready TX request port and a one-cycle RX result strobe toward the register/FIFO layer.
- Supports all four CPOL/CPHA modes, 1..CHAR_NBITS bit characters, MSB- or LSB-first.

Parameters:
- CHAR_NBITS, 16, maximum character length in bits.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= CHAR_NBITS.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low aborts any transfer.
- cpol  in  1  clock polarity.
- cpha  in  1  clock phase.
- char_len  in  CNT_W  character length minus 1.
- lsb_first  in  1  1 = LSB shifted first.
- tx_valid  in  1  TX character request.
- tx_ready  out  1  controller can accept a character.
- tx_data  in  CHAR_NBITS  character to send.
- rx_valid  out  1  one-cycle strobe; rx_data is valid.
- rx_data  out  CHAR_NBITS  received character, right-justified, upper bits 0.
- go  out  1  to clk_gen: run SCLK.
- last_clk  out  1  to clk_gen: finish current SCLK period, then stop.
- pos_edge  in  1  from clk_gen, one-sysclk strobe at SCLK rise.
- neg_edge  in  1  from clk_gen, one-sysclk strobe at SCLK fall.
- miso  in  1  serial data in.
- mosi  out  1  serial data out.
- cs_n  out  1  chip select, active-low.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async): state=IDLE; go=0, last_clk=0, tx_ready=0, rx_valid=0, rx_data=0, mosi=0, busy=0, cs_n=1; counters and shift registers cleared.
- Edge roles:
  - lead = (cpol ? neg_edge : pos_edge); trail = the other strobe.
  - CPHA=0: sample on lead, shift on trail.
  - CPHA=1: shift on lead, sample on trail.
  - pos_edge and neg_edge asserted in the same cycle are both ignored.
- Load latching: cpol, cpha, lsb_first and char_len (clamped to CHAR_NBITS-1) are latched at load. Changes to these inputs mid-character have no effect.
- State IDLE:
  - tx_ready = enable.
  - tx_valid & tx_ready -> load tx shift register, bit_cnt = char_len, cs_n <= 0.
  - mosi <= first bit: tx_data[char_len] if MSB-first, tx_data[0] if LSB-first.
  - Next state SETUP.
- State SETUP: exactly 1 cycle, CS-to-clock setup. go <= 1; next state XFER.
- State XFER, on each lead:
  - If bit_cnt==0: last_clk <= 1, next state LAST.
  - Else: bit_cnt decrements.
  - CPHA=1: shift out the next bit on every lead except the first.
- State XFER, sampling and shifting:
  - Sample: the k-th received bit (k=0..char_len) goes to rx_sh[k] if LSB-first; if MSB-first, rx_sh shifts left with miso inserted at bit 0.
  - CPHA=0 trail: shift out the next bit.
- State LAST:
  - Sample on the final sample edge as in XFER.
  - On trail: go <= 0, last_clk <= 0, rx_data <= rx_sh, next state DONE.
  - No MOSI shift on the final trail; mosi holds the last bit.
- State DONE: 1 cycle.
  - rx_valid = 1; tx_ready = enable.
  - tx_valid -> load next character with cs_n held low, next state SETUP (burst).
  - Otherwise cs_n <= 1, next state IDLE.
- Output timing:
  - rx_valid is high only in DONE.
  - go rises 2 cycles after accept.
  - Exactly char_len+1 lead strobes occur per character while go=1.
- Abort: enable low in any state -> next cycle go=0, last_clk=0, cs_n=1, state IDLE. No rx_valid; rx_data unchanged.
- Reset mid-transfer: immediate return to reset values; cs_n high without waiting for sysclk.

Test Plan:
- Mode 0, char_len=7, MSB-first, tx 0xA5, miso looped from mosi -> 8 pos_edge while go=1; rx_data=0x00A5; rx_valid high 1 cycle; cs_n=1 one cycle after DONE.
- Mode 3 (cpol=1, cpha=1), char_len=15, lsb_first=1, tx 0x1234, miso loopback -> 16 neg_edge leads; mosi first bit 0; rx_data=0x1234; go falls on the pos_edge after the 16th lead.
- Burst: two requests 0x3C then 0xC3, tx_valid held, mode 1, char_len=7 -> cs_n stays low across both; two rx_valid pulses with 0x003C, 0x00C3; SETUP gap of 1 cycle between characters.
- char_len=20 with CHAR_NBITS=16 -> clamped to 16 bits; exactly 16 lead strobes.
- enable dropped after 3 leads of an 8-bit transfer -> go=0, cs_n=1 next cycle; no rx_valid; tx_ready=0 until enable returns.
- rst_n asserted mid-character -> cs_n=1, go=0 immediately; after release, a new 0x5A transfer completes correctly.
